// File: rtl/bus_pkg.sv
// Shared encodings for the data bus responder: access-size codes and FSM state type.
package bus_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/data_ram.sv
// Word-organised backing store: synchronous byte-enabled write, registered read.
module data_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_bus_responder.sv
// Core-facing load/store responder with programmable wait states, lane steering,
// sign/zero extension and access fault detection in front of a word RAM.
module data_bus_responder
    import bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_read,
    input  logic        bus_write,
    input  logic [31:0] bus_addr,
    input  logic [1:0]  bus_size,
    input  logic        bus_unsigned,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_stall,
    output logic        bus_done,
    output logic        bus_fault
);

    localparam int         ADDR_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [1:0] WAIT_INIT = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    function automatic logic access_fault(input logic rd, input logic wr,
                                          input logic [1:0] size, input logic [31:0] addr);
        logic f;
        f = rd && wr;
        f = f || (size == 2'b11);
        f = f || ((size == SIZE_HALF) && addr[0]);
        f = f || ((size == SIZE_WORD) && (addr[1:0] != 2'b00));
        f = f || ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
        return f;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: return uns ? {24'h0, b} : {{24{b[7]}}, b};
            SIZE_HALF: return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default:   return word;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        fault_q, fault_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        ld_vld_q, ld_vld_d;
    logic [1:0]  ld_lane_q, ld_lane_d;
    logic [1:0]  ld_size_q, ld_size_d;
    logic        ld_uns_q, ld_uns_d;

    logic        commit;
    logic [31:0] eff_addr;
    logic [31:0] eff_wdata;
    logic [1:0]  eff_size;
    logic        eff_uns;
    logic        eff_rd;
    logic        eff_wr;
    logic        eff_fault;
    logic        ram_we;
    logic        ram_re;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    // The commit edge is the acceptance edge when WAIT_STATES=0, so live inputs are used in IDLE.
    always_comb begin
        if (state_q == IDLE) begin
            eff_addr  = bus_addr;
            eff_wdata = bus_wdata;
            eff_size  = bus_size;
            eff_uns   = bus_unsigned;
            eff_rd    = bus_read;
            eff_wr    = bus_write;
        end else begin
            eff_addr  = addr_q;
            eff_wdata = wdata_q;
            eff_size  = size_q;
            eff_uns   = uns_q;
            eff_rd    = rd_q;
            eff_wr    = wr_q;
        end
        eff_fault = access_fault(eff_rd, eff_wr, eff_size, eff_addr);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus_read || bus_write) begin
                    addr_d  = bus_addr;
                    wdata_d = bus_wdata;
                    size_d  = bus_size;
                    uns_d   = bus_unsigned;
                    rd_d    = bus_read;
                    wr_d    = bus_write;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!(bus_read || bus_write)) begin
                    state_d = IDLE;
                    cnt_d   = 2'd0;
                end else if (cnt_q == 2'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fault_d   = commit ? eff_fault : fault_q;
        ram_we    = commit && !eff_fault && eff_wr && !eff_rd && !reset;
        ram_re    = commit && !eff_fault && eff_rd && !eff_wr && !reset;
        ld_vld_d  = ld_vld_q || ram_re;
        ld_lane_d = ram_re ? eff_addr[1:0] : ld_lane_q;
        ld_size_d = ram_re ? eff_size : ld_size_q;
        ld_uns_d  = ram_re ? eff_uns : ld_uns_q;
        case (eff_size)
            SIZE_BYTE: begin
                ram_be    = 4'b0001 << eff_addr[1:0];
                ram_wdata = {4{eff_wdata[7:0]}};
            end
            SIZE_HALF: begin
                ram_be    = eff_addr[1] ? 4'b1100 : 4'b0011;
                ram_wdata = {2{eff_wdata[15:0]}};
            end
            default: begin
                ram_be    = 4'b1111;
                ram_wdata = eff_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            fault_q  <= 1'b0;
            ld_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fault_q  <= fault_d;
            ld_vld_q <= ld_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q    <= addr_d;
        wdata_q   <= wdata_d;
        size_q    <= size_d;
        uns_q     <= uns_d;
        rd_q      <= rd_d;
        wr_q      <= wr_d;
        ld_lane_q <= ld_lane_d;
        ld_size_q <= ld_size_d;
        ld_uns_q  <= ld_uns_d;
    end

    data_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (ram_be),
        .re    (ram_re),
        .addr  (eff_addr[ADDR_W+1:2]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Load data is formatted from registers that all update on the edge entering RESP.
    assign bus_rdata = ld_vld_q ? load_extend(ram_rdata, ld_lane_q, ld_size_q, ld_uns_q) : 32'h0;
    assign bus_stall = ((state_q == IDLE) && (bus_read || bus_write)) || (state_q == WAIT);
    assign bus_done  = (state_q == RESP);
    assign bus_fault = (state_q == RESP) && fault_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Randomized bench for data_bus_responder against a byte-array reference model.
module tb_data_bus_responder;

    localparam int DEPTH = 256;
    localparam int WS    = 1;
    localparam int MBYTES = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_read, bus_write, bus_unsigned;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [1:0]  bus_size;
    logic        bus_stall, bus_done, bus_fault;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  mbytes [MBYTES];
    logic [31:0] model_rdata;

    data_bus_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus_read     (bus_read),
        .bus_write    (bus_write),
        .bus_addr     (bus_addr),
        .bus_size     (bus_size),
        .bus_unsigned (bus_unsigned),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_stall    (bus_stall),
        .bus_done     (bus_done),
        .bus_fault    (bus_fault)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic model_fault(input logic rd, input logic wr,
                                         input logic [1:0] size, input logic [31:0] addr);
        int nb;
        if (rd && wr) return 1'b1;
        if (size == 2'd3) return 1'b1;
        nb = 1 << size;
        if ((addr % nb) != 0) return 1'b1;
        if ((addr / 4) >= DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    // Apply the model effect of one completed access.
    task automatic model_apply(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [1:0] size, input logic uns, input logic [31:0] wdata);
        int nb;
        logic [31:0] v;
        if (model_fault(rd, wr, size, addr) || addr >= MBYTES) return;
        nb = 1 << size;
        if (wr) begin
            for (int k = 0; k < nb; k++) mbytes[addr + k] = wdata[8*k +: 8];
        end else begin
            v = 32'h0;
            for (int k = 0; k < nb; k++) v[8*k +: 8] = mbytes[addr + k];
            if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 32'h1);
            model_rdata = v;
        end
    endtask

    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [1:0] size, input logic uns, input logic [31:0] wdata);
        int cyc;
        @(posedge clk); #1;
        check_eq("done_pulse", 32'(bus_done), 32'h0);
        bus_read = rd; bus_write = wr; bus_addr = addr;
        bus_size = size; bus_unsigned = uns; bus_wdata = wdata;
        #1;
        check_eq("stall_req", 32'(bus_stall), 32'h1);
        cyc = 0;
        while (cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
            if (bus_done) break;
            check_eq("stall_wait", 32'(bus_stall), 32'h1);
            bus_addr = $urandom; bus_wdata = $urandom; bus_size = 2'($urandom); bus_unsigned = 1'($urandom);
        end
        check_eq("latency", 32'(cyc), 32'(1 + WS));
        model_apply(rd, wr, addr, size, uns, wdata);
        check_eq("fault", 32'(bus_fault), 32'(model_fault(rd, wr, size, addr)));
        check_eq("rdata", bus_rdata, model_rdata);
        check_eq("stall_resp", 32'(bus_stall), 32'h0);
        bus_read = 1'b0; bus_write = 1'b0;
    endtask

    initial begin
        logic        rd, wr;
        logic [31:0] a;
        reset = 1'b1; bus_read = 1'b0; bus_write = 1'b0; bus_addr = 32'h0;
        bus_size = 2'b10; bus_unsigned = 1'b0; bus_wdata = 32'h0;
        model_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_done", 32'(bus_done), 32'h0);
        check_eq("rst_fault", 32'(bus_fault), 32'h0);
        check_eq("rst_rdata", bus_rdata, 32'h0);
        check_eq("rst_stall", 32'(bus_stall), 32'h0);
        reset = 1'b0;

        for (int w = 0; w < MBYTES / 4; w++) do_access(1'b0, 1'b1, 32'(w * 4), 2'b10, 1'b0, $urandom);

        do_access(1'b0, 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
        do_access(1'b1, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
        check_eq("lw_10", bus_rdata, 32'hDEADBEEF);

        do_access(1'b0, 1'b1, 32'h20, 2'b10, 1'b0, 32'h80FF7F01);
        do_access(1'b1, 1'b0, 32'h23, 2'b00, 1'b0, 32'h0);
        check_eq("lb_23", bus_rdata, 32'hFFFFFF80);
        do_access(1'b1, 1'b0, 32'h23, 2'b00, 1'b1, 32'h0);
        check_eq("lbu_23", bus_rdata, 32'h00000080);
        do_access(1'b1, 1'b0, 32'h22, 2'b01, 1'b0, 32'h0);
        check_eq("lh_22", bus_rdata, 32'hFFFF80FF);
        do_access(1'b1, 1'b0, 32'h20, 2'b01, 1'b1, 32'h0);
        check_eq("lhu_20", bus_rdata, 32'h00007F01);

        do_access(1'b0, 1'b1, 32'h20, 2'b10, 1'b0, 32'h11223344);
        do_access(1'b0, 1'b1, 32'h21, 2'b00, 1'b0, 32'h000000AA);
        do_access(1'b1, 1'b0, 32'h20, 2'b10, 1'b1, 32'h0);
        check_eq("sb_21", bus_rdata, 32'h1122AA44);

        do_access(1'b0, 1'b1, 32'h00, 2'b10, 1'b0, 32'h0BADF00D);
        do_access(1'b1, 1'b0, 32'h02, 2'b10, 1'b0, 32'h0);
        check_eq("lw_02_flt", 32'(bus_fault), 32'h1);
        check_eq("lw_02_hold", bus_rdata, 32'h0BADF00D ^ 32'h0BADF00D ^ model_rdata);
        do_access(1'b0, 1'b1, 32'h01, 2'b01, 1'b0, 32'h0000FFFF);
        check_eq("sh_01_flt", 32'(bus_fault), 32'h1);
        do_access(1'b0, 1'b1, 32'h400, 2'b10, 1'b0, 32'h12345678);
        check_eq("oob_flt", 32'(bus_fault), 32'h1);
        do_access(1'b1, 1'b0, 32'h00, 2'b10, 1'b0, 32'h0);
        check_eq("mem_keep", bus_rdata, 32'h0BADF00D);

        // Reset while a store waits: the store must not land.
        @(posedge clk); #1;
        bus_write = 1'b1; bus_addr = 32'h10; bus_size = 2'b10; bus_wdata = 32'h55AA55AA;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("rstw_done", 32'(bus_done), 32'h0);
        check_eq("rstw_fault", 32'(bus_fault), 32'h0);
        check_eq("rstw_rdata", bus_rdata, 32'h0);
        check_eq("rstw_stall", 32'(bus_stall), 32'h1);
        bus_write = 1'b0; reset = 1'b0; model_rdata = 32'h0;
        do_access(1'b1, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
        check_eq("rstw_mem", bus_rdata, 32'hDEADBEEF);

        // Request withdrawn during the wait: no completion, no write.
        @(posedge clk); #1;
        bus_write = 1'b1; bus_addr = 32'h24; bus_size = 2'b10; bus_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("abort_done", 32'(bus_done), 32'h0);
        end
        do_access(1'b1, 1'b0, 32'h24, 2'b10, 1'b0, 32'h0);
        check_eq("abort_mem", bus_rdata, {mbytes[39], mbytes[38], mbytes[37], mbytes[36]});

        for (int n = 0; n < 150; n++) begin
            rd = 1'($urandom_range(0, 1));
            wr = !rd;
            if ($urandom_range(0, 19) == 0) begin rd = 1'b1; wr = 1'b1; end
            if ($urandom_range(0, 9) == 0) a = 32'h400 + 32'($urandom_range(0, 255));
            else a = 32'($urandom_range(0, MBYTES - 1));
            do_access(rd, wr, a, 2'($urandom_range(0, 3)), 1'($urandom), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
